// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: funct3 codes, FSM states
// and the request legality checks.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STORE,
        S_LOAD,
        S_ERR,
        S_RESP
    } lsu_state_t;

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3)
            F3_H, F3_HU: return off[0];
            F3_W:        return off != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

    function automatic logic is_illegal(input logic store, input logic [2:0] funct3,
                                        input logic [1:0] off);
        logic bad_f3;
        if (store) bad_f3 = !(funct3 inside {F3_B, F3_H, F3_W});
        else       bad_f3 = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        return bad_f3 || is_misaligned(funct3, off);
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response channel between the core's exec stage and the LSU.
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for big-endian BRAM words: store placement/enables on the
// request side, lane extraction and sign/zero extension on the load side.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_off,
    input  logic [31:0] wdata,
    output logic [31:0] din,
    output logic [3:0]  we,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] dout,
    output logic [31:0] rdata
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        din = wdata;
        we  = 4'b0000;
        case (st_funct3)
            F3_B: begin
                din = {4{wdata[7:0]}};
                we  = 4'b1000 >> st_off;
            end
            F3_H: begin
                din = {2{wdata[15:0]}};
                we  = st_off[1] ? 4'b0011 : 4'b1100;
            end
            F3_W:    we = 4'b1111;
            default: we = 4'b0000;
        endcase
    end

    // Byte offset k lives at bits [31-8k:24-8k], so shift right by (3-k)*8.
    always_comb begin
        byte_sel = 8'(dout >> {~ld_off, 3'b000});
        half_sel = ld_off[1] ? dout[15:0] : dout[31:16];
        case (ld_funct3)
            F3_B:    rdata = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   rdata = {24'b0, byte_sel};
            F3_H:    rdata = {{16{half_sel[15]}}, half_sel};
            F3_HU:   rdata = {16'b0, half_sel};
            default: rdata = dout;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit owning the data-BRAM port; one op in flight, response
// pulse after the store write, the BRAM read latency, or an error.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W       = 15,
    parameter int READ_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rstn,
    lsu_if.slave              bus,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic [3:0]        mem_we,
    input  logic [31:0]       mem_dout
);

    lsu_state_t  state;
    logic [2:0]  cnt;
    logic [2:0]  op_funct3;
    logic [1:0]  op_off;
    logic [31:0] store_din;
    logic [3:0]  store_we;
    logic [31:0] load_rdata;
    logic        req_illegal;

    assign req_illegal = is_illegal(bus.req_store, bus.req_funct3, bus.req_addr[1:0]);

    lsu_align u_align (
        .st_funct3 (bus.req_funct3),
        .st_off    (bus.req_addr[1:0]),
        .wdata     (bus.req_wdata),
        .din       (store_din),
        .we        (store_we),
        .ld_funct3 (op_funct3),
        .ld_off    (op_off),
        .dout      (mem_dout),
        .rdata     (load_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state          <= S_IDLE;
            cnt            <= 3'd0;
            op_funct3      <= 3'd0;
            op_off         <= 2'd0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= 32'd0;
            bus.resp_err   <= 1'b0;
            mem_addr       <= '0;
            mem_din        <= 32'd0;
            mem_we         <= 4'd0;
        end else begin
            bus.resp_valid <= 1'b0;
            mem_we         <= 4'd0;
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        bus.req_ready <= 1'b0;
                        op_funct3     <= bus.req_funct3;
                        op_off        <= bus.req_addr[1:0];
                        if (req_illegal) begin
                            state <= S_ERR;
                        end else begin
                            // Upper address bits drop out here, giving the wrap.
                            mem_addr <= ADDR_W'(bus.req_addr >> 2);
                            if (bus.req_store) begin
                                mem_din <= store_din;
                                mem_we  <= store_we;
                                state   <= S_STORE;
                            end else begin
                                cnt   <= 3'(READ_LATENCY);
                                state <= S_LOAD;
                            end
                        end
                    end
                end
                S_STORE: begin
                    bus.resp_rdata <= 32'd0;
                    bus.resp_err   <= 1'b0;
                    bus.resp_valid <= 1'b1;
                    state          <= S_RESP;
                end
                S_LOAD: begin
                    if (cnt == 3'd0) begin
                        bus.resp_rdata <= load_rdata;
                        bus.resp_err   <= 1'b0;
                        bus.resp_valid <= 1'b1;
                        state          <= S_RESP;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                S_ERR: begin
                    bus.resp_rdata <= 32'd0;
                    bus.resp_err   <= 1'b1;
                    bus.resp_valid <= 1'b1;
                    state          <= S_RESP;
                end
                S_RESP: begin
                    bus.req_ready <= 1'b1;
                    state         <= S_IDLE;
                end
                default: begin
                    bus.req_ready <= 1'b1;
                    state         <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: default-latency instance with a 2-stage BRAM model
// and a READ_LATENCY=1 instance with a 1-stage model.
module tb_lsu;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    lsu_if bus_a ();
    lsu_if bus_b ();

    logic [14:0] mem_addr_a, mem_addr_b;
    logic [31:0] mem_din_a, mem_din_b, mem_dout_a, mem_dout_b;
    logic [3:0]  mem_we_a, mem_we_b;

    lsu #(.ADDR_W(15), .READ_LATENCY(2)) dut_a (
        .clk(clk), .rstn(rstn), .bus(bus_a.slave),
        .mem_addr(mem_addr_a), .mem_din(mem_din_a), .mem_we(mem_we_a), .mem_dout(mem_dout_a)
    );

    lsu #(.ADDR_W(15), .READ_LATENCY(1)) dut_b (
        .clk(clk), .rstn(rstn), .bus(bus_b.slave),
        .mem_addr(mem_addr_b), .mem_din(mem_din_b), .mem_we(mem_we_b), .mem_dout(mem_dout_b)
    );

    logic [31:0] ram_a [0:32767];
    logic [31:0] ram_b [0:32767];
    logic [31:0] pipe_a0, pipe_a1, pipe_b0;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we_a[i]) ram_a[mem_addr_a][8*i +: 8] <= mem_din_a[8*i +: 8];
            if (mem_we_b[i]) ram_b[mem_addr_b][8*i +: 8] <= mem_din_b[8*i +: 8];
        end
        pipe_a0 <= ram_a[mem_addr_a];
        pipe_a1 <= pipe_a0;
        pipe_b0 <= ram_b[mem_addr_b];
    end
    assign mem_dout_a = pipe_a1;
    assign mem_dout_b = pipe_b0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    logic [31:0] r_rdata, r_din_t1;
    logic [14:0] r_addr_t1;
    logic [3:0]  r_we_t1;
    logic        r_err, r_we_any, r_rdy_hi;
    int          r_lat, r_wait;

    // One op on instance A; r_lat counts cycles from handshake to resp_valid.
    task automatic op_a(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input bit hold);
        @(negedge clk);
        bus_a.req_valid  = 1'b1;
        bus_a.req_store  = st;
        bus_a.req_funct3 = f3;
        bus_a.req_addr   = a;
        bus_a.req_wdata  = wd;
        r_wait = 0;
        while (!bus_a.req_ready && r_wait < 50) begin
            @(negedge clk);
            r_wait++;
        end
        @(posedge clk);
        #1;
        if (!hold) bus_a.req_valid = 1'b0;
        r_we_t1   = mem_we_a;
        r_din_t1  = mem_din_a;
        r_addr_t1 = mem_addr_a;
        r_we_any  = |mem_we_a;
        r_rdy_hi  = bus_a.req_ready;
        r_lat     = 1;
        while (!bus_a.resp_valid && r_lat < 50) begin
            @(posedge clk);
            #1;
            r_lat++;
            r_we_any = r_we_any | (|mem_we_a);
            r_rdy_hi = r_rdy_hi | bus_a.req_ready;
        end
        r_rdata = bus_a.resp_rdata;
        r_err   = bus_a.resp_err;
    endtask

    task automatic ld_a(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] exp);
        op_a(1'b0, f3, a, 32'd0, 1'b0);
        chk(tag, r_rdata, exp);
    endtask

    int  lat_b, wt;
    logic rv_seen;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0;
        bus_a.req_valid = 1'b0; bus_a.req_store = 1'b0; bus_a.req_funct3 = 3'd0;
        bus_a.req_addr  = 32'd0; bus_a.req_wdata = 32'd0;
        bus_b.req_valid = 1'b0; bus_b.req_store = 1'b0; bus_b.req_funct3 = 3'd0;
        bus_b.req_addr  = 32'd0; bus_b.req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus_a.req_ready), 32'd1);
        chk("rst_rvalid", 32'(bus_a.resp_valid), 32'd0);
        chk("rst_rdata", bus_a.resp_rdata, 32'd0);
        chk("rst_err", 32'(bus_a.resp_err), 32'd0);
        chk("rst_we", 32'(mem_we_a), 32'd0);
        chk("rst_addr", 32'(mem_addr_a), 32'd0);
        chk("rst_din", mem_din_a, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        op_a(1'b1, F3_W, 32'h100, 32'hDEADBEEF, 1'b0);
        chk("sw_we", 32'(r_we_t1), 32'hF);
        chk("sw_din", r_din_t1, 32'hDEADBEEF);
        chk("sw_addr", 32'(r_addr_t1), 32'h40);
        chk("sw_lat", 32'(r_lat), 32'd2);
        chk("sw_err", 32'(r_err), 32'd0);
        chk("sw_rdata", r_rdata, 32'd0);
        op_a(1'b0, F3_W, 32'h100, 32'd0, 1'b0);
        chk("lw_data", r_rdata, 32'hDEADBEEF);
        chk("lw_lat", 32'(r_lat), 32'd4);

        op_a(1'b1, F3_W, 32'h100, 32'h0, 1'b0);
        op_a(1'b1, F3_B, 32'h101, 32'h123456AA, 1'b0);
        chk("sb_we", 32'(r_we_t1), 32'b0100);
        chk("sb_din", r_din_t1, 32'hAAAAAAAA);
        ld_a("lw_after_sb", F3_W, 32'h100, 32'h00AA0000);
        ld_a("lbu_101", F3_BU, 32'h101, 32'h000000AA);

        op_a(1'b1, F3_W, 32'h200, 32'h80FF7F01, 1'b0);
        ld_a("lb_200", F3_B, 32'h200, 32'hFFFFFF80);
        ld_a("lbu_200", F3_BU, 32'h200, 32'h00000080);
        ld_a("lh_202", F3_H, 32'h202, 32'h00007F01);
        ld_a("lhu_200", F3_HU, 32'h200, 32'h000080FF);
        ld_a("lh_200", F3_H, 32'h200, 32'hFFFF80FF);
        ld_a("lb_201", F3_B, 32'h201, 32'hFFFFFFFF);
        ld_a("lb_203", F3_B, 32'h203, 32'h00000001);
        ld_a("lhu_202", F3_HU, 32'h202, 32'h00007F01);

        op_a(1'b1, F3_H, 32'h103, 32'h5555, 1'b0);
        chk("sh_mis_err", 32'(r_err), 32'd1);
        chk("sh_mis_lat", 32'(r_lat), 32'd2);
        chk("sh_mis_we", 32'(r_we_any), 32'd0);
        chk("sh_mis_rdata", r_rdata, 32'd0);
        op_a(1'b0, F3_W, 32'h102, 32'd0, 1'b0);
        chk("lw_mis_err", 32'(r_err), 32'd1);
        chk("lw_mis_lat", 32'(r_lat), 32'd2);
        ld_a("lw_unchanged", F3_W, 32'h100, 32'h00AA0000);
        chk("lw_ok_err", 32'(r_err), 32'd0);
        op_a(1'b0, 3'b111, 32'h100, 32'd0, 1'b0);
        chk("ld_f3_111_err", 32'(r_err), 32'd1);
        op_a(1'b1, F3_BU, 32'h100, 32'hFFFFFFFF, 1'b0);
        chk("st_f3_100_err", 32'(r_err), 32'd1);
        chk("st_f3_100_we", 32'(r_we_any), 32'd0);

        op_a(1'b1, F3_H, 32'h102, 32'hBEEF1234, 1'b0);
        chk("sh_we", 32'(r_we_t1), 32'b0011);
        chk("sh_din", r_din_t1, 32'h12341234);
        ld_a("lw_after_sh", F3_W, 32'h100, 32'h00AA1234);
        ld_a("lw_wrap", F3_W, 32'h00020100, 32'h00AA1234);
        chk("wrap_addr", 32'(r_addr_t1), 32'h40);

        op_a(1'b1, F3_W, 32'h300, 32'hCAFEF00D, 1'b1);
        chk("b2b_st_busy", 32'(r_rdy_hi), 32'd0);
        op_a(1'b0, F3_W, 32'h300, 32'd0, 1'b1);
        chk("b2b_accept_gap", 32'(r_wait), 32'd1);
        chk("b2b_ld_busy", 32'(r_rdy_hi), 32'd0);
        chk("b2b_ld_data", r_rdata, 32'hCAFEF00D);
        chk("b2b_ld_lat", 32'(r_lat), 32'd4);
        @(negedge clk);
        bus_a.req_valid = 1'b0;

        // Abort a load in S_LOAD with reset.
        @(negedge clk);
        bus_a.req_valid = 1'b1; bus_a.req_store = 1'b0;
        bus_a.req_funct3 = F3_W; bus_a.req_addr = 32'h300;
        @(posedge clk);
        #1;
        bus_a.req_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_rvalid", 32'(bus_a.resp_valid), 32'd0);
        chk("abort_we", 32'(mem_we_a), 32'd0);
        chk("abort_ready", 32'(bus_a.req_ready), 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        rv_seen = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            rv_seen = rv_seen | bus_a.resp_valid;
        end
        chk("abort_no_resp", 32'(rv_seen), 32'd0);
        ld_a("lw_after_abort", F3_W, 32'h300, 32'hCAFEF00D);
        chk("lat_after_abort", 32'(r_lat), 32'd4);

        // READ_LATENCY=1 instance: store then load, load resp at T+3.
        @(negedge clk);
        bus_b.req_valid = 1'b1; bus_b.req_store = 1'b1; bus_b.req_funct3 = F3_W;
        bus_b.req_addr = 32'h40; bus_b.req_wdata = 32'h13579BDF;
        @(posedge clk);
        #1;
        bus_b.req_valid = 1'b0;
        wt = 0;
        while (!bus_b.req_ready && wt < 50) begin
            @(negedge clk);
            wt++;
        end
        @(negedge clk);
        bus_b.req_valid = 1'b1; bus_b.req_store = 1'b0; bus_b.req_funct3 = F3_HU;
        bus_b.req_addr = 32'h42;
        @(posedge clk);
        #1;
        bus_b.req_valid = 1'b0;
        lat_b = 1;
        while (!bus_b.resp_valid && lat_b < 50) begin
            @(posedge clk);
            #1;
            lat_b++;
        end
        chk("rl1_lat", 32'(lat_b), 32'd3);
        chk("rl1_lhu_data", bus_b.resp_rdata, 32'h00009BDF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
